// File: rtl/dual_input_debounce.sv
// Two-channel 2-flop synchronizer + stability-counter debouncer feeding simple_or.in_a/in_b.
// Optional macro DEBOUNCE_EDGE_EN adds registered one-cycle rising-edge pulses on out_a_rise/out_b_rise.
module dual_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw_a,
  input  logic in_raw_b,
  output logic out_a,
  output logic out_b,
  output logic out_a_rise,
  output logic out_b_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("dual_input_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  // Index 0 is channel A, index 1 is channel B; the channels share no state.
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       lvl;
  logic [1:0]       lvl_nxt;
  logic [CNT_W-1:0] cnt     [2];
  logic [CNT_W-1:0] cnt_nxt [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl_nxt[i] = lvl[i];
      cnt_nxt[i] = '0;
      if (s2[i] != lvl[i]) begin
        if (cnt[i] == CNT_LAST) begin
          lvl_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      lvl <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1  <= {in_raw_b, in_raw_a};
      s2  <= s1;
      lvl <= lvl_nxt;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign out_a = lvl[0];
  assign out_b = lvl[1];

`ifdef DEBOUNCE_EDGE_EN
  // Pulse lines up with the first cycle the debounced level reads 1.
  logic [1:0] rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= '0;
    end else begin
      rise <= lvl_nxt & ~lvl;
    end
  end

  assign out_a_rise = rise[0];
  assign out_b_rise = rise[1];
`else
  assign out_a_rise = 1'b0;
  assign out_b_rise = 1'b0;
`endif

endmodule

// File: tb/tb_dual_input_debounce.sv
// Bench: one DUT with DEBOUNCE_CYCLES=4 (bits 0,1) and one with DEBOUNCE_CYCLES=1 (bits 2,3).
module tb_dual_input_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] raw;
  logic [3:0] out;
  logic [3:0] rise;

  int checks = 0;
  int errors = 0;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  dual_input_debounce #(.DEBOUNCE_CYCLES(4)) u_d4 (
    .clk(clk), .rst(rst),
    .in_raw_a(raw[0]), .in_raw_b(raw[1]),
    .out_a(out[0]), .out_b(out[1]),
    .out_a_rise(rise[0]), .out_b_rise(rise[1])
  );

  dual_input_debounce #(.DEBOUNCE_CYCLES(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in_raw_a(raw[2]), .in_raw_b(raw[3]),
    .out_a(out[2]), .out_b(out[3]),
    .out_a_rise(rise[2]), .out_b_rise(rise[3])
  );

  // Reference: the synced stream is the raw level two edges late; the output
  // flips once that stream has disagreed with it on D consecutive edges.
  bit d1_q [4];
  bit d2_q [4];
  bit mout [4];
  bit mrise[4];
  int run  [4];

  function automatic int dcyc(input int c);
    return (c < 2) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (rst) begin
        d1_q[c] = 1'b0; d2_q[c] = 1'b0; mout[c] = 1'b0; mrise[c] = 1'b0; run[c] = 0;
      end else begin
        mrise[c] = 1'b0;
        if (d2_q[c] != mout[c]) begin
          run[c] = run[c] + 1;
          if (run[c] >= dcyc(c)) begin
            mout[c]  = d2_q[c];
            mrise[c] = d2_q[c];
            run[c]   = 0;
          end
        end else begin
          run[c] = 0;
        end
        d2_q[c] = d1_q[c];
        d1_q[c] = raw[c];
      end
    end
  end

  function automatic logic [3:0] exp_out();
    return {mout[3], mout[2], mout[1], mout[0]};
  endfunction

  function automatic logic [3:0] exp_rise();
    return EDGE ? {mrise[3], mrise[2], mrise[1], mrise[0]} : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw = 4'($urandom);
    repeat (3) tick();
    checks++;
    if (out !== 4'b0000 || rise !== 4'b0000) begin
      errors++; $display("FAIL reset_state: out=%b rise=%b required 0000/0000", out, rise);
    end
    rst = 1'b0;
    raw = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out !== 4'b0000 || rise !== 4'b0000) begin
        errors++; $display("FAIL idle_zero cyc %0d: out=%b rise=%b required 0000/0000", i, out, rise);
      end
    end
  endtask

  task automatic test_rise_a();
    do_reset();
    tick();
    raw[0] = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      tick();
      checks++;
      if (out[0] !== (i >= 5) || out[1] !== 1'b0) begin
        errors++; $display("FAIL rise_a edge k+%0d: out_a=%b out_b=%b required %b/0", i, out[0], out[1], i >= 5);
      end
      checks++;
      if (rise[0] !== (EDGE && i == 5) || rise[1] !== 1'b0) begin
        errors++; $display("FAIL rise_a_pulse edge k+%0d: rise_a=%b rise_b=%b required %b/0", i, rise[0], rise[1], EDGE && i == 5);
      end
    end
  endtask

  task automatic test_glitch_b();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 6; i++) begin
        raw[1] = (i < 3);
        tick();
        checks++;
        if (out[1] !== 1'b0 || rise[1] !== 1'b0) begin
          errors++; $display("FAIL glitch_b pulse %0d cyc %0d: out_b=%b rise_b=%b required 0/0", p, i, out[1], rise[1]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic or_c;
    do_reset();
    tick();
    raw[1:0] = 2'b11;
    for (int i = 0; i <= 6; i++) begin
      tick();
      or_c = out[0] | out[1];
      checks++;
      if (out[1:0] !== ((i >= 5) ? 2'b11 : 2'b00) || or_c !== (i >= 5)) begin
        errors++; $display("FAIL simultaneous edge k+%0d: out=%b or_c=%b required %b", i, out[1:0], or_c, i >= 5);
      end
      checks++;
      if (rise[1:0] !== ((EDGE && i == 5) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL simultaneous_rise edge k+%0d: rise=%b", i, rise[1:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    raw[0] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out[0] !== 1'b0 || rise[0] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_clear: out_a=%b rise_a=%b required 0/0", out[0], rise[0]);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if (out[0] !== (j >= 6) || rise[0] !== (EDGE && j == 6)) begin
        errors++; $display("FAIL reset_mid edge %0d after rst: out_a=%b rise_a=%b required %b/%b", j, out[0], rise[0], j >= 6, EDGE && j == 6);
      end
    end
  endtask

  task automatic test_debounce1();
    do_reset();
    tick();
    raw[2] = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick();
      checks++;
      if (out[2] !== (i >= 2) || rise[2] !== (EDGE && i == 2)) begin
        errors++; $display("FAIL d1_rise edge k+%0d: out=%b rise=%b required %b/%b", i, out[2], rise[2], i >= 2, EDGE && i == 2);
      end
    end
    raw[2] = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      tick();
      checks++;
      if (out[2] !== (i < 2) || rise[2] !== 1'b0) begin
        errors++; $display("FAIL d1_fall edge k+%0d: out=%b rise=%b required %b/0", i, out[2], rise[2], i < 2);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) raw = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (out !== exp_out() || rise !== exp_rise()) begin
        errors++; $display("FAIL random cyc %0d: out=%b rise=%b required %b/%b", n, out, rise, exp_out(), exp_rise());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    raw = '0;
    test_reset();
    test_rise_a();
    test_glitch_b();
    test_simultaneous();
    test_reset_mid();
    test_debounce1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
